// File: rtl/stepper_phase_decoder.sv
// Purpose: monitor/decoder for a 4-wire one-hot stepper coil bus (direction, position, faults, end-of-motion).
// Latency: a coil change sampled at edge k shows on the outputs after edge k+2 (2-flop sync + 1 registered update).
// Backpressure: none; a free-running observer that never stalls the coil driver it watches.
//
// Ports:
//   clk_cnt    - sampling clock
//   rst        - asynchronous active-high reset
//   coil[3:0]  - coil bus: 0001/0010/0100/1000 = phase 0..3, 0000 = de-energised
//   clr        - synchronous clear of position, counters, revolution state and fault
//   position   - signed step position (wraps mod 2^POS_W)
//   step_total - accepted step count, saturating at 2^POS_W-1
//   dir        - direction of last accepted step (1 = phase +1, 0 = phase -1)
//   moving     - high while the tracker is in RUN
//   done       - one-cycle pulse when RUN times out back to IDLE
//   err        - sticky fault flag (skip or illegal pattern), held until clr/rst
//   rev_cnt    - signed revolution count (8-bit wrap)
//   rev_pulse  - one-cycle pulse on the step that crosses a revolution boundary
//
// Build option: define STEPPER_DEC_REV_EN to build the revolution tracker;
// without it rev_cnt and rev_pulse are tied low.

module stepper_phase_decoder #(
    parameter int POS_W         = 16,
    parameter int STEPS_PER_REV = 48,
    parameter int IDLE_TIMEOUT  = 4
) (
    input  logic                    clk_cnt,
    input  logic                    rst,
    input  logic [3:0]              coil,
    input  logic                    clr,
    output logic signed [POS_W-1:0] position,
    output logic [POS_W-1:0]        step_total,
    output logic                    dir,
    output logic                    moving,
    output logic                    done,
    output logic                    err,
    output logic signed [7:0]       rev_cnt,
    output logic                    rev_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [7:0]              IDLE_LIM  = 8'(IDLE_TIMEOUT);
    localparam logic signed [POS_W-1:0] POS_ONE   = POS_W'(1);
    localparam logic [POS_W-1:0]        TOT_ONE   = POS_W'(1);
    localparam logic [POS_W-1:0]        TOT_MAX   = '1;

`ifdef STEPPER_DEC_REV_EN
    localparam int                 PH_W   = $clog2(STEPS_PER_REV);
    localparam logic [PH_W-1:0]    PH_MAX = PH_W'(STEPS_PER_REV - 1);
    localparam logic [PH_W-1:0]    PH_ONE = PH_W'(1);

    logic [PH_W-1:0] phase_in_rev;
`endif

    state_t     state;
    logic [3:0] coil_m;      // first synchroniser stage
    logic [3:0] coil_s;      // synchronised coil
    logic [3:0] coil_p;      // coil_s one cycle ago, for change detection
    logic [1:0] last_ph;
    logic       last_valid;  // last_ph holds a phase we can step relative to
    logic [7:0] idle_cnt;

    logic       coil_chg;
    logic       is_zero;
    logic       is_onehot;
    logic [1:0] idx;
    logic [1:0] delta;
    logic       step_fwd;
    logic       step_bwd;
    logic       fault_ev;

    // Phase decode of the synchronised bus.
    always_comb begin
        is_onehot = 1'b1;
        idx       = 2'd0;
        case (coil_s)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: is_onehot = 1'b0;
        endcase
    end

    assign coil_chg = (coil_s != coil_p);
    assign is_zero  = (coil_s == 4'b0000);
    // 2-bit subtraction gives the phase distance mod 4 directly.
    assign delta    = idx - last_ph;

    assign step_fwd = coil_chg && is_onehot && last_valid && (delta == 2'd1);
    assign step_bwd = coil_chg && is_onehot && last_valid && (delta == 2'd3);
    // A two-phase jump means a step was missed; anything not 0000/one-hot is a wiring or driver fault.
    assign fault_ev = coil_chg && ((is_onehot && last_valid && (delta == 2'd2)) ||
                                   (!is_zero && !is_onehot));

    always_ff @(posedge clk_cnt or posedge rst) begin
        if (rst) begin
            coil_m       <= '0;
            coil_s       <= '0;
            coil_p       <= '0;
            state        <= IDLE;
            last_ph      <= '0;
            last_valid   <= 1'b0;
            idle_cnt     <= '0;
            position     <= '0;
            step_total   <= '0;
            dir          <= 1'b0;
            moving       <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
`ifdef STEPPER_DEC_REV_EN
            phase_in_rev <= '0;
            rev_cnt      <= '0;
            rev_pulse    <= 1'b0;
`endif
        end else begin
            // Synchroniser and change detector run in every state, so that a
            // clr out of FAULT never sees a stale coil_p as a fresh event.
            coil_m <= coil;
            coil_s <= coil_m;
            coil_p <= coil_s;

            done <= 1'b0;
`ifdef STEPPER_DEC_REV_EN
            rev_pulse <= 1'b0;
`endif

            if (clr) begin
                // Takes priority over any step or fault evaluated this cycle.
                state        <= IDLE;
                moving       <= 1'b0;
                err          <= 1'b0;
                last_valid   <= 1'b0;
                idle_cnt     <= '0;
                position     <= '0;
                step_total   <= '0;
`ifdef STEPPER_DEC_REV_EN
                phase_in_rev <= '0;
                rev_cnt      <= '0;
`endif
            end else if (state != FAULT) begin
                if (fault_ev) begin
                    // Everything freezes until clr or rst.
                    state    <= FAULT;
                    err      <= 1'b1;
                    moving   <= 1'b0;
                    idle_cnt <= '0;
                end else begin
                    if (coil_chg) begin
                        if (is_zero) begin
                            // De-energised: the next one-hot pattern is a resync, not a step.
                            last_valid <= 1'b0;
                        end else begin
                            last_ph    <= idx;
                            last_valid <= 1'b1;
                        end
                    end

                    if (step_fwd) begin
                        position <= position + POS_ONE;
                        dir      <= 1'b1;
                    end
                    if (step_bwd) begin
                        position <= position - POS_ONE;
                        dir      <= 1'b0;
                    end
                    if ((step_fwd || step_bwd) && (step_total != TOT_MAX)) begin
                        step_total <= step_total + TOT_ONE;
                    end

`ifdef STEPPER_DEC_REV_EN
                    if (step_fwd) begin
                        if (phase_in_rev == PH_MAX) begin
                            phase_in_rev <= '0;
                            rev_cnt      <= rev_cnt + 8'sd1;
                            rev_pulse    <= 1'b1;
                        end else begin
                            phase_in_rev <= phase_in_rev + PH_ONE;
                        end
                    end
                    if (step_bwd) begin
                        if (phase_in_rev == '0) begin
                            phase_in_rev <= PH_MAX;
                            rev_cnt      <= rev_cnt - 8'sd1;
                            rev_pulse    <= 1'b1;
                        end else begin
                            phase_in_rev <= phase_in_rev - PH_ONE;
                        end
                    end
`endif

                    case (state)
                        IDLE: begin
                            if (coil_chg && is_onehot) begin
                                state    <= RUN;
                                moving   <= 1'b1;
                                idle_cnt <= '0;
                            end
                        end
                        RUN: begin
                            // Counts samples, not events: a held 0000 keeps counting.
                            if (is_zero) begin
                                if ((idle_cnt + 8'd1) == IDLE_LIM) begin
                                    state    <= IDLE;
                                    moving   <= 1'b0;
                                    done     <= 1'b1;
                                    idle_cnt <= '0;
                                end else begin
                                    idle_cnt <= idle_cnt + 8'd1;
                                end
                            end else begin
                                idle_cnt <= '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifndef STEPPER_DEC_REV_EN
    // Revolution tracker not built; STEPS_PER_REV has no effect in this build.
    assign rev_cnt   = '0;
    assign rev_pulse = 1'b0;
`endif

endmodule

// File: doc/stepper_phase_decoder.md
# stepper_phase_decoder

Monitor and decoder for the 4-wire one-hot coil bus produced by the stepper motor drivers. It samples a coil bus (red, yellow or blue), recovers step direction and signed position, detects skipped or illegal phase patterns, and flags end-of-motion. It sits beside each driver in the dispenser datapath as position feedback and self-check for the sequencing FSM.

## Interface
- POS_W, 16, width of position and step_total.
- STEPS_PER_REV, 48, steps per output revolution; must be 2 or more.
- IDLE_TIMEOUT, 4, consecutive 0000 samples needed to declare motion finished; 1 to 255.
- clk_cnt  in  1  sampling clock.
- rst  in  1  reset, asynchronous, active-high.
- coil  in  4  coil bus: 0001=phase 0, 0010=phase 1, 0100=phase 2, 1000=phase 3, 0000=de-energised.
- clr  in  1  synchronous clear of position, counters and fault.
- position  out  POS_W  signed step position, two's complement.
- step_total  out  POS_W  unsigned count of accepted steps, saturating.
- dir  out  1  direction of last accepted step: 1 = phase index +1, 0 = phase index -1.
- moving  out  1  high while in RUN.
- done  out  1  one-cycle pulse on RUN->IDLE.
- err  out  1  sticky fault flag; high in FAULT.
- rev_cnt  out  8  signed revolution count (macro-dependent).
- rev_pulse  out  1  one-cycle pulse on revolution boundary crossing (macro-dependent).

## Operation
- Input path: 2-flop synchroniser on coil to give coil_s; coil_p holds the previous coil_s.
- Tracking registers: last_ph[1:0], last_valid, idle_cnt.
- An event is evaluated only when coil_s != coil_p.
- coil_s == 0000: clear last_valid; no step.
- coil_s one-hot with last_valid = 0 (resync): last_ph = index, last_valid = 1, no step.
- coil_s one-hot with last_valid = 1, d = (index - last_ph) mod 4:
  - d = 1: position +1, dir = 1.
  - d = 3: position -1, dir = 0.
  - d = 2: skip fault.
  - Then last_ph = index.
- coil_s not in {0000, one-hot}: illegal fault.
- Every accepted step increments step_total, saturating at 2^POS_W-1. Position wraps mod 2^POS_W.
- FSM states:
  - IDLE: any one-hot coil_s -> RUN (resync).
  - RUN: idle_cnt counts consecutive 0000 samples and resets on any non-zero sample. idle_cnt reaching IDLE_TIMEOUT -> IDLE with done = 1 for one cycle.
  - Any state, fault -> FAULT, err = 1.
  - FAULT: all counters frozen; exits only via clr or rst.
- clr: position, step_total, rev state, err and last_valid are zeroed; state -> IDLE; no done pulse.
  - clr wins over a simultaneous step or fault in the same cycle.
- moving = (state == RUN).

## Timing
- Coil change sampled at edge k is visible on outputs after edge k+2: synchroniser at k and k+1, registered update at k+2.
- The coil bus must change at most once per clk_cnt period. Faster changes are undefined, and the block may flag a skip fault.
- done asserts on the edge where the IDLE_TIMEOUT-th consecutive 0000 sample is evaluated, and lasts one cycle.
- rev_pulse is coincident with the step that crosses the boundary.
- Reset values: position 0, step_total 0, dir 0, moving 0, done 0, err 0, rev_cnt 0, rev_pulse 0, state IDLE, last_valid 0.
- Reset mid-motion: the first one-hot pattern after release is a resync and produces no step.

## Configuration
- STEPPER_DEC_REV_EN defined:
  - A phase_in_rev counter runs 0..STEPS_PER_REV-1.
  - +1 step from STEPS_PER_REV-1 wraps to 0, increments rev_cnt (8-bit wrap) and pulses rev_pulse.
  - -1 step from 0 wraps to STEPS_PER_REV-1, decrements rev_cnt and pulses rev_pulse.
  - clr zeroes phase_in_rev and rev_cnt.
- STEPPER_DEC_REV_EN undefined: no revolution logic is built; rev_cnt and rev_pulse are tied 0; ports remain.

## Test plan
- Reset, then coil 0001,1000,0100,0010,0001 one per cycle -> position -4, dir 0, step_total 4, moving 1, err 0.
- Coil 0001,0010,0100,1000, then 0000 held 4 cycles (IDLE_TIMEOUT 4) -> position +3, dir 1, single done pulse, moving 0.
- Coil 0001 then 0100 -> err 1, state FAULT; further valid steps leave position unchanged; clr -> err 0, position 0, IDLE.
- Coil 0011 mid-run -> err 1. Then clr asserted in the same cycle as a valid step -> position 0, step_total 0.
- STEPPER_DEC_REV_EN defined, STEPS_PER_REV 4, 8 forward steps then 1 backward step -> rev_pulse on steps 4 and 8, then on the backward step; rev_cnt 2 then 1.
- Run to position +5, then 0000 for 2 cycles, then 0001 -> resync, position stays 5, no done pulse, moving stays 1.
